// File: rtl/rng_byte_buffer_if.sv
// Byte-buffer bus between the de-bias stage / UART and rng_byte_buffer.
//   bit_valid, bit_in : de-biased bit stream in
//   tx_ready          : UART idle
//   tx_start, tx_byte : byte hand-off to UART
//   fifo_count        : bytes stored (0..2**ADDR_BITS)
//   overflow          : sticky, byte dropped on full FIFO
//   health_fail       : sticky, repetition-count test tripped
// master = bit source / UART side, slave = rng_byte_buffer.
interface rng_byte_buffer_if #(
  parameter int ADDR_BITS = 4
);
  logic                 bit_valid;
  logic                 bit_in;
  logic                 tx_ready;
  logic                 tx_start;
  logic [7:0]           tx_byte;
  logic [ADDR_BITS:0]   fifo_count;
  logic                 overflow;
  logic                 health_fail;

  modport master (
    output bit_valid, bit_in, tx_ready,
    input  tx_start, tx_byte, fifo_count, overflow, health_fail
  );

  modport slave (
    input  bit_valid, bit_in, tx_ready,
    output tx_start, tx_byte, fifo_count, overflow, health_fail
  );
endinterface

// File: rtl/rng_byte_buffer.sv
// rng_byte_buffer: packs de-biased bits LSB-first into bytes, runs a
// repetition-count health test on the bit stream, buffers bytes in a FIFO
// and hands them to the UART one at a time via the tx_ready handshake.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high, clears all state
//   bus   : rng_byte_buffer_if.slave (bit input, UART hand-off, status)
module rng_byte_buffer #(
  parameter int ADDR_BITS  = 4,
  parameter int RCT_CUTOFF = 32
) (
  input  logic               clk,
  input  logic               reset,
  rng_byte_buffer_if.slave   bus
);
  localparam int                 DEPTH  = 2**ADDR_BITS;
  localparam logic [7:0]         CUTOFF = 8'(RCT_CUTOFF);
  localparam logic [ADDR_BITS:0] FULL   = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] ONE    = (ADDR_BITS+1)'(1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t               state, state_nxt;
  logic [1:0]           busy_cnt, busy_cnt_nxt;
  logic [2:0]           idx;
  logic [7:0]           shreg;
  logic [7:0]           run_len, run_nxt;
  logic                 last_bit;
  logic                 health_fail;
  logic                 overflow;
  logic [ADDR_BITS-1:0] wptr, rptr;
  logic [ADDR_BITS:0]   count;
  logic [7:0]           tx_byte_q;
  logic [7:0]           mem [DEPTH];

  logic       trip, byte_done, push_req, push, pop;
  logic [7:0] byte_new;

  // Repetition count: a fresh run starts at 1, repeats saturate at cutoff.
  always_comb begin
    run_nxt = 8'd1;
    if (run_len != 8'd0 && bus.bit_in == last_bit)
      run_nxt = (run_len == CUTOFF) ? CUTOFF : run_len + 8'd1;
  end

  assign trip      = bus.bit_valid && (run_nxt == CUTOFF);
  assign byte_done = bus.bit_valid && (idx == 3'd7);
  assign byte_new  = {bus.bit_in, shreg[6:0]};
  // A byte completing on the tripping bit is discarded along with the FIFO.
  assign push_req  = byte_done && !health_fail && !trip;
  assign push      = push_req && (count != FULL);

  // Output FSM; pop doubles as tx_start so the head is offered in the same
  // cycle the FSM sees a non-empty FIFO.
  always_comb begin
    state_nxt    = state;
    busy_cnt_nxt = busy_cnt;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && bus.tx_ready && !health_fail) begin
          pop          = 1'b1;
          state_nxt    = WAIT_BUSY;
          busy_cnt_nxt = 2'd0;
        end
      end
      WAIT_BUSY: begin
        if (!bus.tx_ready) begin
          state_nxt = WAIT_DONE;
        end else if (busy_cnt == 2'd3) begin
          // UART never went busy: assume it took the byte.
          state_nxt = IDLE;
        end else begin
          busy_cnt_nxt = busy_cnt + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      busy_cnt <= busy_cnt_nxt;
    end
  end

  // Bit assembly and health test.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= 3'd0;
      shreg       <= 8'd0;
      run_len     <= 8'd0;
      last_bit    <= 1'b0;
      health_fail <= 1'b0;
    end else if (bus.bit_valid) begin
      shreg[idx] <= bus.bit_in;
      idx        <= idx + 3'd1;
      run_len    <= run_nxt;
      last_bit   <= bus.bit_in;
      if (trip) health_fail <= 1'b1;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      tx_byte_q <= 8'd0;
    end else begin
      if (push_req && count == FULL) overflow <= 1'b1;
      if (pop) tx_byte_q <= mem[rptr];
      if (trip) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + ONE;
          2'b01:   count <= count - ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= byte_new;
  end

  assign bus.tx_start    = pop;
  assign bus.tx_byte     = pop ? mem[rptr] : tx_byte_q;
  assign bus.fifo_count  = count;
  assign bus.overflow    = overflow;
  assign bus.health_fail = health_fail;
endmodule

// File: tb/tb_rng_byte_buffer.sv
// Directed bench for rng_byte_buffer with a byte scoreboard: expected bytes
// are queued as their last bit is driven and checked on each tx_start.
module tb_rng_byte_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bv = 1'b0, bi = 1'b0;
  logic man_rdy = 1'b1;
  logic uart_en = 1'b0;
  logic uart_rdy = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int start_cnt = 0;
  int s0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  rng_byte_buffer_if #(.ADDR_BITS(4)) ifc ();
  assign ifc.bit_valid = bv;
  assign ifc.bit_in    = bi;
  assign ifc.tx_ready  = uart_en ? uart_rdy : man_rdy;

  rng_byte_buffer #(.ADDR_BITS(4), .RCT_CUTOFF(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every tx_start must match the next expected byte.
  always @(negedge clk) begin
    if (!reset && ifc.tx_start) begin
      start_cnt++;
      chk("start_ready", ifc.tx_ready, 1'b1);
      chk("start_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("tx_byte", ifc.tx_byte, sb.pop_front());
    end
  end

  // UART model: goes busy the cycle after tx_start, for 100 cycles.
  always begin
    @(negedge clk);
    if (uart_en && ifc.tx_start) begin
      @(posedge clk); #1 uart_rdy = 1'b0;
      repeat (100) @(posedge clk);
      #1 uart_rdy = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b);
    bv = 1'b1; bi = b;
    tick();
    bv = 1'b0;
  endtask

  // Returns right after the edge that consumes bit 7.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit exp_out);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && exp_out) sb.push_back(b);
      send_bit(b[i]);
      if (i < 7) repeat (gap) tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; bv = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    #1;
    while (!ifc.tx_start && n < 300) begin tick(); n++; end
    chk(tag, ifc.tx_start, 1'b1);
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (ifc.fifo_count != 0 && n < 600) begin tick(); n++; end
    repeat (6) tick();
    chk(tag, ifc.fifo_count, 0);
    chk({tag, "_sb"}, sb.size(), 0);
  endtask

  initial begin
    logic [62:0] pat;
    logic [7:0]  acc;
    int          nb;

    // Reset state
    do_reset();
    chk("rst_tx_start", ifc.tx_start, 0);
    chk("rst_tx_byte", ifc.tx_byte, 0);
    chk("rst_count", ifc.fifo_count, 0);
    chk("rst_overflow", ifc.overflow, 0);
    chk("rst_health", ifc.health_fail, 0);

    // 1: basic order and one-cycle latency
    man_rdy = 1'b1;
    s0 = start_cnt;
    send_byte(8'hA5, 1, 1);
    chk("t1_lat_a5", ifc.tx_start, 1);
    chk("t1_byte_a5", ifc.tx_byte, 8'hA5);
    tick();
    send_byte(8'h3C, 1, 1);
    chk("t1_lat_3c", ifc.tx_start, 1);
    wait_empty("t1_empty");
    chk("t1_starts", start_cnt - s0, 2);
    chk("t1_hold", ifc.tx_byte, 8'h3C);

    // 2: UART handshake with long busy periods
    man_rdy = 1'b0;
    send_byte(8'h11, 0, 1);
    send_byte(8'h22, 0, 1);
    send_byte(8'h33, 0, 1);
    tick();
    chk("t2_count3", ifc.fifo_count, 3);
    s0 = start_cnt;
    uart_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_start("t2_start");
      tick();
      chk("t2_count", ifc.fifo_count, 32'(2 - k));
    end
    repeat (110) tick();
    chk("t2_starts", start_cnt - s0, 3);
    uart_en = 1'b0;

    // 3: overflow, 17th byte dropped
    man_rdy = 1'b0;
    for (int v = 1; v <= 17; v++) send_byte(8'(v), 0, v <= 16);
    tick();
    chk("t3_full", ifc.fifo_count, 16);
    chk("t3_overflow", ifc.overflow, 1);
    man_rdy = 1'b1;
    wait_empty("t3_drain");

    // 4: push and pop in the same cycle
    man_rdy = 1'b0;
    send_byte(8'h77, 0, 1);
    chk("t4_count1", ifc.fifo_count, 1);
    pat[7:0] = 8'h99;
    for (int i = 0; i < 7; i++) send_bit(pat[i]);
    sb.push_back(8'h99);
    man_rdy = 1'b1;
    send_bit(pat[7]);
    chk("t4_count_same", ifc.fifo_count, 1);
    wait_empty("t4_drain");

    // 5: repetition-count trip flushes FIFO and blocks output
    man_rdy = 1'b0;
    for (int k = 0; k < 5; k++) send_byte(8'h55, 0, 0);
    chk("t5_count5", ifc.fifo_count, 5);
    for (int i = 0; i < 31; i++) send_bit(1'b1);
    chk("t5_health_31", ifc.health_fail, 0);
    chk("t5_count8", ifc.fifo_count, 8);
    send_bit(1'b1);
    chk("t5_health_32", ifc.health_fail, 1);
    chk("t5_flushed", ifc.fifo_count, 0);
    sb.delete();
    s0 = start_cnt;
    man_rdy = 1'b1;
    repeat (20) tick();
    chk("t5_no_start", start_cnt - s0, 0);
    chk("t5_overflow_sticky", ifc.overflow, 1);

    // 6: run of 31 is legal; reset discards partial bytes
    do_reset();
    chk("t6_rst_health", ifc.health_fail, 0);
    chk("t6_rst_overflow", ifc.overflow, 0);
    chk("t6_rst_byte", ifc.tx_byte, 0);
    pat = {31'h7FFF_FFFF, 1'b0, 31'h7FFF_FFFF};
    acc = 8'd0; nb = 0;
    for (int i = 0; i < 63; i++) begin
      acc[nb] = pat[i];
      nb++;
      if (nb == 8) begin sb.push_back(acc); nb = 0; end
      send_bit(pat[i]);
    end
    chk("t6_health_ok", ifc.health_fail, 0);
    wait_empty("t6_drain");
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    do_reset();
    send_byte(8'h5A, 0, 1);
    chk("t6_lat_5a", ifc.tx_start, 1);
    chk("t6_byte_5a", ifc.tx_byte, 8'h5A);
    wait_empty("t6_final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
